// File: rtl/riscv_mdu_sequencer.sv
// Execute-stage sequencer for the M-extension multiplier and divider.
// Optional divide/remainder fusion cache: define RISCV_MDUSQ_DIVREM_FUSE_EN.
module riscv_mdu_sequencer #(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 3
) (
  input  logic              i_riscv_mdusq_clk,
  input  logic              i_riscv_mdusq_rst,
  input  logic              i_riscv_mdusq_mul_en,
  input  logic              i_riscv_mdusq_div_en,
  input  logic [2:0]        i_riscv_mdusq_funct3,
  input  logic              i_riscv_mdusq_word,
  input  logic [XLEN-1:0]   i_riscv_mdusq_rs1,
  input  logic [XLEN-1:0]   i_riscv_mdusq_rs2,
  input  logic              i_riscv_mdusq_kill,
  input  logic              i_riscv_mdusq_hold,
  input  logic [2*XLEN-1:0] i_riscv_mdusq_mul_product,
  input  logic              i_riscv_mdusq_div_done,
  input  logic [XLEN-1:0]   i_riscv_mdusq_div_quot,
  input  logic [XLEN-1:0]   i_riscv_mdusq_div_rem,
  output logic              o_riscv_mdusq_mul_start,
  output logic              o_riscv_mdusq_div_start,
  output logic              o_riscv_mdusq_div_abort,
  output logic [XLEN-1:0]   o_riscv_mdusq_op_a,
  output logic [XLEN-1:0]   o_riscv_mdusq_op_b,
  output logic              o_riscv_mdusq_sign_a,
  output logic              o_riscv_mdusq_sign_b,
  output logic [XLEN-1:0]   o_riscv_mdusq_result,
  output logic              o_riscv_mdusq_valid,
  output logic              o_riscv_mdusq_busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic w);
    word_fix = w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] prep_op(input logic [XLEN-1:0] v, input logic w,
                                              input logic s);
    if (!w)     prep_op = v;
    else if (s) prep_op = {{(XLEN-32){v[31]}}, v[31:0]};
    else        prep_op = {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  // Prepared W operands are already sign-extended, so the low word decides.
  function automatic logic is_min(input logic [XLEN-1:0] v, input logic w);
    if (w) is_min = (v[31:0] == 32'h8000_0000);
    else   is_min = (v == {1'b1, {(XLEN-1){1'b0}}});
  endfunction

  state_t state_q, state_d;

  logic              sgn_a_p0, sgn_b_p0;
  logic [XLEN-1:0]   op_a_p0, op_b_p0;
  logic              div_zero_p0, div_ovf_p0, special_p0;
  logic [XLEN-1:0]   spec_raw_p0, spec_res_p0;

  logic [XLEN-1:0]   op_a_p1, op_b_p1;
  logic              sign_a_p1, sign_b_p1;
  logic [2:0]        f3_p1;
  logic              word_p1;
  logic [CNT_W-1:0]  cnt_q;
  logic              mul_start_q, div_start_q;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept_mul, accept_div, take_special, take_cache;
  logic              cap_mul, cap_div, load_res;
  logic              cache_hit;
  logic [XLEN-1:0]   cache_res;

  // Stage p0: decode signedness and prepare operands from the E-stage request
  always_comb begin
    sgn_a_p0 = (i_riscv_mdusq_funct3 == 3'd1) || (i_riscv_mdusq_funct3 == 3'd2) ||
               (i_riscv_mdusq_funct3 == 3'd4) || (i_riscv_mdusq_funct3 == 3'd6);
    sgn_b_p0 = (i_riscv_mdusq_funct3 == 3'd1) || (i_riscv_mdusq_funct3 == 3'd4) ||
               (i_riscv_mdusq_funct3 == 3'd6);
  end

  assign op_a_p0     = prep_op(i_riscv_mdusq_rs1, i_riscv_mdusq_word, sgn_a_p0);
  assign op_b_p0     = prep_op(i_riscv_mdusq_rs2, i_riscv_mdusq_word, sgn_b_p0);
  assign div_zero_p0 = (op_b_p0 == '0);
  assign div_ovf_p0  = sgn_b_p0 && is_min(op_a_p0, i_riscv_mdusq_word) && (&op_b_p0);
  assign special_p0  = div_zero_p0 || div_ovf_p0;

  always_comb begin
    if (div_zero_p0) spec_raw_p0 = i_riscv_mdusq_funct3[1] ? op_a_p0 : '1;
    else             spec_raw_p0 = i_riscv_mdusq_funct3[1] ? '0 : op_a_p0;
    spec_res_p0 = word_fix(spec_raw_p0, i_riscv_mdusq_word);
  end

`ifdef RISCV_MDUSQ_DIVREM_FUSE_EN
  logic            cache_vld;
  logic [XLEN-1:0] cache_a, cache_b, cache_quot, cache_rem;
  logic            cache_sa, cache_sb, cache_w;

  always_ff @(posedge i_riscv_mdusq_clk) begin
    if (i_riscv_mdusq_rst) cache_vld <= 1'b0;
    else if (cap_div)      cache_vld <= 1'b1;
  end

  // Cache stores raw divider outputs; W fix-up is reapplied on a hit.
  always_ff @(posedge i_riscv_mdusq_clk) begin
    if (cap_div) begin
      cache_a    <= op_a_p1;
      cache_b    <= op_b_p1;
      cache_sa   <= sign_a_p1;
      cache_sb   <= sign_b_p1;
      cache_w    <= word_p1;
      cache_quot <= i_riscv_mdusq_div_quot;
      cache_rem  <= i_riscv_mdusq_div_rem;
    end
  end

  assign cache_hit = cache_vld && (cache_a == op_a_p0) && (cache_b == op_b_p0) &&
                     (cache_sa == sgn_a_p0) && (cache_sb == sgn_b_p0) &&
                     (cache_w == i_riscv_mdusq_word);
  assign cache_res = word_fix(i_riscv_mdusq_funct3[1] ? cache_rem : cache_quot,
                              i_riscv_mdusq_word);
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // Control: kill overrides every state, including a held DONE
  always_comb begin
    state_d      = state_q;
    accept_mul   = 1'b0;
    accept_div   = 1'b0;
    take_special = 1'b0;
    take_cache   = 1'b0;
    cap_mul      = 1'b0;
    cap_div      = 1'b0;
    if (i_riscv_mdusq_kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_riscv_mdusq_mul_en) begin
            state_d    = MUL_WAIT;
            accept_mul = 1'b1;
          end else if (i_riscv_mdusq_div_en) begin
            if (special_p0) begin
              state_d      = DONE;
              take_special = 1'b1;
            end else if (cache_hit) begin
              state_d    = DONE;
              take_cache = 1'b1;
            end else begin
              state_d    = DIV_WAIT;
              accept_div = 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt_q == '0) begin
            state_d = DONE;
            cap_mul = 1'b1;
          end
        end
        DIV_WAIT: begin
          if (i_riscv_mdusq_div_done) begin
            state_d = DONE;
            cap_div = 1'b1;
          end
        end
        DONE: begin
          if (!i_riscv_mdusq_hold) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign load_res = cap_mul || cap_div || take_special || take_cache;

  always_comb begin
    result_d = result_q;
    if (cap_mul)
      result_d = word_fix((f3_p1 == 3'd0) ? i_riscv_mdusq_mul_product[XLEN-1:0]
                                          : i_riscv_mdusq_mul_product[2*XLEN-1:XLEN], word_p1);
    else if (cap_div)
      result_d = word_fix(f3_p1[1] ? i_riscv_mdusq_div_rem : i_riscv_mdusq_div_quot, word_p1);
    else if (take_special)
      result_d = spec_res_p0;
    else if (take_cache)
      result_d = cache_res;
  end

  // Stage p1: registered operands, start pulses, latency counter and result
  always_ff @(posedge i_riscv_mdusq_clk) begin
    if (i_riscv_mdusq_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      op_a_p1     <= '0;
      op_b_p1     <= '0;
      sign_a_p1   <= 1'b0;
      sign_b_p1   <= 1'b0;
      f3_p1       <= '0;
      word_p1     <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mul_start_q <= accept_mul;
      div_start_q <= accept_div;
      if (accept_mul || accept_div) begin
        op_a_p1   <= op_a_p0;
        op_b_p1   <= op_b_p0;
        sign_a_p1 <= sgn_a_p0;
        sign_b_p1 <= sgn_b_p0;
        f3_p1     <= i_riscv_mdusq_funct3;
        word_p1   <= i_riscv_mdusq_word;
      end
      if (accept_mul)
        cnt_q <= CNT_W'(MUL_LAT);
      else if ((state_q == MUL_WAIT) && (cnt_q != '0))
        cnt_q <= cnt_q - 1'b1;
      if (load_res) result_q <= result_d;
    end
  end

  assign o_riscv_mdusq_mul_start = mul_start_q;
  assign o_riscv_mdusq_div_start = div_start_q;
  assign o_riscv_mdusq_div_abort = (state_q == DIV_WAIT) && i_riscv_mdusq_kill && !i_riscv_mdusq_rst;
  assign o_riscv_mdusq_op_a      = op_a_p1;
  assign o_riscv_mdusq_op_b      = op_b_p1;
  assign o_riscv_mdusq_sign_a    = sign_a_p1;
  assign o_riscv_mdusq_sign_b    = sign_b_p1;
  assign o_riscv_mdusq_result    = result_q;
  assign o_riscv_mdusq_valid     = (state_q == DONE) && !i_riscv_mdusq_kill && !i_riscv_mdusq_rst;
  assign o_riscv_mdusq_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_riscv_mdu_sequencer.sv
// Scoreboard bench for riscv_mdu_sequencer with behavioural multiplier and divider models.
module tb_riscv_mdu_sequencer;

  localparam int XLEN    = 64;
  localparam int MUL_LAT = 3;
  localparam int DIV_CYC = 34;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mul_en = 1'b0, div_en = 1'b0;
  logic [2:0]        funct3 = '0;
  logic              word = 1'b0;
  logic [XLEN-1:0]   rs1 = '0, rs2 = '0;
  logic              kill = 1'b0, hold = 1'b0;
  logic [2*XLEN-1:0] mul_product;
  logic              div_done;
  logic [XLEN-1:0]   div_quot, div_rem;
  logic              mul_start, div_start, div_abort;
  logic [XLEN-1:0]   op_a, op_b, result;
  logic              sign_a, sign_b, valid, busy;

  always #5 clk = ~clk;

  riscv_mdu_sequencer #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .i_riscv_mdusq_clk        (clk),
    .i_riscv_mdusq_rst        (rst),
    .i_riscv_mdusq_mul_en     (mul_en),
    .i_riscv_mdusq_div_en     (div_en),
    .i_riscv_mdusq_funct3     (funct3),
    .i_riscv_mdusq_word       (word),
    .i_riscv_mdusq_rs1        (rs1),
    .i_riscv_mdusq_rs2        (rs2),
    .i_riscv_mdusq_kill       (kill),
    .i_riscv_mdusq_hold       (hold),
    .i_riscv_mdusq_mul_product(mul_product),
    .i_riscv_mdusq_div_done   (div_done),
    .i_riscv_mdusq_div_quot   (div_quot),
    .i_riscv_mdusq_div_rem    (div_rem),
    .o_riscv_mdusq_mul_start  (mul_start),
    .o_riscv_mdusq_div_start  (div_start),
    .o_riscv_mdusq_div_abort  (div_abort),
    .o_riscv_mdusq_op_a       (op_a),
    .o_riscv_mdusq_op_b       (op_b),
    .o_riscv_mdusq_sign_a     (sign_a),
    .o_riscv_mdusq_sign_b     (sign_b),
    .o_riscv_mdusq_result     (result),
    .o_riscv_mdusq_valid      (valid),
    .o_riscv_mdusq_busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined multiplier: product visible MUL_LAT cycles after the start cycle, junk otherwise
  logic signed [XLEN:0]     m_a, m_b;
  logic signed [2*XLEN+1:0] m_full;
  logic [2*XLEN-1:0]        p_data [MUL_LAT];
  logic                     p_vld  [MUL_LAT];
  assign m_a    = {sign_a & op_a[XLEN-1], op_a};
  assign m_b    = {sign_b & op_b[XLEN-1], op_b};
  assign m_full = m_a * m_b;
  always @(posedge clk) begin
    p_data[0] <= m_full[2*XLEN-1:0];
    p_vld[0]  <= mul_start;
    for (int i = 1; i < MUL_LAT; i++) begin
      p_data[i] <= p_data[i-1];
      p_vld[i]  <= p_vld[i-1];
    end
  end
  assign mul_product = p_vld[MUL_LAT-1] ? p_data[MUL_LAT-1] : {2{64'hA5A5_5A5A_DEAD_BEEF}};

  // Iterative divider: done pulses DIV_CYC cycles after the start cycle
  int              dcnt = 0;
  logic [XLEN-1:0] d_quot = '0, d_rem = '0;
  always @(posedge clk) begin
    if (rst || div_abort) dcnt <= 0;
    else if (div_start) begin
      dcnt <= DIV_CYC;
      if (op_b == '0) begin
        d_quot <= '1;
        d_rem  <= op_a;
      end else if (sign_a) begin
        d_quot <= XLEN'($signed(op_a) / $signed(op_b));
        d_rem  <= XLEN'($signed(op_a) % $signed(op_b));
      end else begin
        d_quot <= op_a / op_b;
        d_rem  <= op_a % op_b;
      end
    end else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign div_done = (dcnt == 1);
  assign div_quot = d_quot;
  assign div_rem  = d_rem;

  typedef struct {
    logic [XLEN-1:0] res;
    int              t;
    int              lat;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, pops the scoreboard on each new valid
  exp_t cur;
  bit   have = 0;
  logic valid_prev = 1'b0;
  int   run = 0, last_run = 0;
  int   n_mul_st = 0, n_div_st = 0, n_abort = 0, mul_st_cyc = 0;
  initial forever begin
    @(negedge clk);
    if (valid) begin
      if (!valid_prev) begin
        run = 0;
        if (sb.size() == 0) begin
          have = 0;
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          cur  = sb.pop_front();
          have = 1;
          check("latency", 64'(cyc - cur.t), 64'(cur.lat));
        end
      end
      run++;
      if (have) check("result", result, cur.res);
    end else if (valid_prev) begin
      last_run = run;
    end
    valid_prev = valid;
    if (mul_start) begin
      n_mul_st++;
      mul_st_cyc = cyc;
    end
    if (div_start) n_div_st++;
    if (div_abort) n_abort++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit m, input bit d, input logic [2:0] f3, input bit w,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit push,
                       input logic [XLEN-1:0] exp_res, input int lat, output int t);
    exp_t e;
    tick();
    mul_en = m; div_en = d; funct3 = f3; word = w; rs1 = a; rs2 = b;
    t = cyc;
    if (push) begin
      e.res = exp_res; e.t = t; e.lat = lat;
      sb.push_back(e);
    end
    tick();
    mul_en = 1'b0; div_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || valid) && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check({tag, "_idle_timeout"}, 64'(k), 64'd0);
    tick();
    tick();
  endtask

  task automatic run_op(input string name, input bit m, input bit d, input logic [2:0] f3,
                        input bit w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_res, input int lat, input int n_ms,
                        input int n_ds);
    int t;
    int m0 = n_mul_st;
    int d0 = n_div_st;
    issue(m, d, f3, w, a, b, 1'b1, exp_res, lat, t);
    wait_idle(name);
    check({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    check({name, "_valid_cycles"}, 64'(last_run), 64'd1);
    check({name, "_mul_starts"}, 64'(n_mul_st - m0), 64'(n_ms));
    check({name, "_div_starts"}, 64'(n_div_st - d0), 64'(n_ds));
    if (n_ms != 0) check({name, "_mul_start_cyc"}, 64'(mul_st_cyc), 64'(t + 1));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_starts"}, 64'({mul_start, div_start, div_abort}), 64'd0);
    check({tag, "_signs"}, 64'({sign_a, sign_b}), 64'd0);
    check({tag, "_op_a"}, op_a, '0);
    check({tag, "_op_b"}, op_b, '0);
    check({tag, "_result"}, result, '0);
  endtask

  initial begin
    int t, a0, d0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst = 1'b0;

    run_op("mul",    1, 0, 3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 5, 1, 0);
    run_op("mulhu",  1, 0, 3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 5, 1, 0);
    run_op("mulw",   1, 0, 3'd0, 1, 64'h8000_0000, 64'd2, 64'd0, 5, 1, 0);
    run_op("mulh",   1, 0, 3'd1, 0, '1, '1, 64'd0, 5, 1, 0);
    run_op("mulhsu", 1, 0, 3'd2, 0, '1, '1, '1, 5, 1, 0);

    run_op("div0",   0, 1, 3'd4, 0, 64'd20, 64'd0, '1, 1, 0, 0);
    run_op("rem0",   0, 1, 3'd6, 0, 64'd20, 64'd0, 64'd20, 1, 0, 0);
    run_op("remw_ovf", 0, 1, 3'd6, 1, 64'h8000_0000, '1, 64'd0, 1, 0, 0);
    run_op("divw_ovf", 0, 1, 3'd4, 1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);

    run_op("divu",   0, 1, 3'd5, 0, 64'd100, 64'd7, 64'd14, DIV_CYC + 2, 0, 1);
`ifdef RISCV_MDUSQ_DIVREM_FUSE_EN
    run_op("remu_fused", 0, 1, 3'd7, 0, 64'd100, 64'd7, 64'd2, 1, 0, 0);
`else
    run_op("remu",   0, 1, 3'd7, 0, 64'd100, 64'd7, 64'd2, DIV_CYC + 2, 0, 1);
`endif
    // Upper operand bits are junk; the W op must use the sign-extended low word (-20 / 3)
    run_op("divw",   0, 1, 3'd4, 1, 64'h1234_5678_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA,
           DIV_CYC + 2, 0, 1);

    // Kill two cycles into DIV_WAIT
    a0 = n_abort;
    d0 = n_div_st;
    issue(0, 1, 3'd4, 0, 64'd1000, 64'd3, 1'b0, '0, 0, t);
    while (cyc < t + 3) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", 64'(busy), 64'd0);
    check("kill_abort_pulses", 64'(n_abort - a0), 64'd1);
    check("kill_div_starts", 64'(n_div_st - d0), 64'd1);
    repeat (40) tick();
    run_op("mul_after_kill", 1, 0, 3'd0, 0, 64'd6, 64'd7, 64'd42, 5, 1, 0);

    // hold high during the first three DONE cycles; valid lasts through the release cycle
    hold = 1'b1;
    issue(1, 0, 3'd0, 0, 64'd5, 64'd5, 1'b1, 64'd25, 5, t);
    while (cyc < t + 8) tick();
    hold = 1'b0;
    wait_idle("hold");
    check("hold_valid_cycles", 64'(last_run), 64'd4);
    check("hold_sb_drained", 64'(sb.size()), 64'd0);

    // Reset while in MUL_WAIT
    issue(1, 0, 3'd0, 0, 64'd3, 64'd3, 1'b0, '0, 0, t);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("reset_mul_wait");
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_mdu_sequencer.md
Name: riscv_mdu_sequencer

Overview:
- Controller for the M-extension resources in the execute stage: one fixed-latency pipelined multiplier and one iterative divider with a done flag.
- Accepts mul/div requests from the E stage and prepares operands, including RV64 W-op truncation.
- Issues start pulses, counts multiplier latency and waits for divider done.
- Resolves divide-by-zero and signed overflow without using the divider.
- Drives the single-cycle valid that releases the hazard-unit multiply/divide stall (stall = (mul_en|div_en) & !valid).

Parameters:
- XLEN, 64, datapath width.
- MUL_LAT, 3, cycles from o_mul_start to i_mul_product valid; legal range 1..15.

Ports:
- i_riscv_mdusq_clk  in  1  core clock
- i_riscv_mdusq_rst  in  1  synchronous active-high reset
- i_riscv_mdusq_mul_en  in  1  E-stage multiply request (funct3 0-3)
- i_riscv_mdusq_div_en  in  1  E-stage divide/remainder request (funct3 4-7)
- i_riscv_mdusq_funct3  in  3  M-op select
- i_riscv_mdusq_word  in  1  W-variant (MULW/DIVW/...)
- i_riscv_mdusq_rs1  in  XLEN  operand A
- i_riscv_mdusq_rs2  in  XLEN  operand B
- i_riscv_mdusq_kill  in  1  E-stage kill (trap/interrupt)
- i_riscv_mdusq_hold  in  1  E stage held by a non-M-extension stall
- i_riscv_mdusq_mul_product  in  2*XLEN  multiplier product
- i_riscv_mdusq_div_done  in  1  divider finished (1-cycle pulse)
- i_riscv_mdusq_div_quot  in  XLEN  quotient
- i_riscv_mdusq_div_rem  in  XLEN  remainder
- o_riscv_mdusq_mul_start  out  1  multiplier start pulse
- o_riscv_mdusq_div_start  out  1  divider start pulse
- o_riscv_mdusq_div_abort  out  1  divider abort pulse
- o_riscv_mdusq_op_a  out  XLEN  prepared operand A (registered)
- o_riscv_mdusq_op_b  out  XLEN  prepared operand B (registered)
- o_riscv_mdusq_sign_a  out  1  treat op_a as signed
- o_riscv_mdusq_sign_b  out  1  treat op_b as signed
- o_riscv_mdusq_result  out  XLEN  final result
- o_riscv_mdusq_valid  out  1  result valid; drives the hazard-unit valid input
- o_riscv_mdusq_busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0, including result and op registers; latency counter 0. Reset mid-operation returns to IDLE next edge. No abort pulse is issued; the divider shares the reset.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, request present, kill low, cycle T:
  - mul_en: latch prepared operands; go MUL_WAIT with mul_start=1 at T+1; counter=MUL_LAT.
  - div_en with rs2 operand==0, or signed and A==MIN and B==-1: compute special result; go DONE at T+1.
  - Otherwise div: go DIV_WAIT with div_start=1 at T+1.
- mul_en and div_en both high is illegal; mul takes priority.
- Operand prep:
  - W ops use low 32 bits, sign-extended if signed, else zero-extended.
  - sign_a: set for MULH, MULHSU, DIV, REM.
  - sign_b: set for MULH, DIV, REM.
- MUL_WAIT: counter decrements each cycle. At 0, capture product and go DONE. MUL/MULW take the low half; MULH* take the high half.
- DIV_WAIT: on div_done, capture quot (DIV*) or rem (REM*) and go DONE.
- Special results:
  - Divide by zero: quot = all ones; rem = A.
  - Overflow: quot = A; rem = 0.
- W results: sign-extend bit 31 to XLEN, including special results.
- DONE: valid=1. If hold=1, stay in DONE with result and valid stable. Otherwise go IDLE next cycle. A new request is never accepted in the same cycle as valid.
- Latency (request to valid): mul MUL_LAT+2; div = divider cycles+2; special 1.
- Kill, any state, has priority over everything:
  - Next state IDLE; valid forced 0 that cycle.
  - div_abort=1 for one cycle if the current state is DIV_WAIT.
  - An in-flight product is ignored.
  - A div_done arriving in the kill cycle is discarded.
- Start and abort are exactly one-cycle pulses.

Optional Feature:
- RISCV_MDUSQ_DIVREM_FUSE_EN defined: keep a cache of the last divider quot, rem, operands, signedness and word flag, plus a valid bit.
  - Cache valid bit: set on completed DIV_WAIT; cleared only by reset.
  - A div request whose prepared operands, signedness and word flag match the cache returns the cached quot/rem via DONE at T+1 (latency 1) with no div_start.
- Undefined: no cache; every non-special div uses the divider.

Test Plan:
- MUL, A=7, B=-3, MUL_LAT=3 → mul_start one cycle after request; valid at T+5; result=-21; stall released exactly one cycle.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MULW, A=0x8000_0000, B=2 → result 0.
- DIV A=20 B=0 → valid at T+1; result 0xFFFF_FFFF_FFFF_FFFF. REMW A=0x8000_0000 B=-1 → 0. DIVW same operands → 0xFFFF_FFFF_8000_0000. No div_start in any of these.
- DIVU A=100 B=7, divider done after 34 cycles → result 14. REMU with same operands → 2. With the fuse macro defined, the REMU completes at T+1 with no div_start.
- Kill asserted two cycles into DIV_WAIT → one div_abort pulse; IDLE next cycle; no valid. A following MUL is accepted normally.
- hold=1 for 3 cycles while in DONE → valid and result held 3 cycles, then IDLE. Reset asserted in MUL_WAIT → all outputs 0 next cycle.
